sram_serial_host: RTL and testbench

Serial initiator for the SRAM_IO_CTRL serial port. Accepts one parallel SRAM write or read request, serializes it as an {address, data} frame on SI under BGN, and waits for the responder's RDY. For reads it captures the returned byte from SO. It replaces the hand-driven SI/BGN stimulus as the on-chip loader for instruction and data images.

---
 rtl/sram_serial_host.sv | 167 ++++++++++++++++
 tb/tb_sram_serial_host.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_serial_host.sv
// sram_serial_host: serial initiator framing one SRAM write/read as {addr, data} on SI under BGN.
// Optional macro SRAM_HOST_TIMEOUT_EN bounds the wait for RDY and reports TIMEOUT_ERR.
`default_nettype none

module sram_serial_host #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int REG_BITS_WIDTH    = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH,
  parameter int TIMEOUT_CYC       = 32
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         REQ_VALID,
  output logic                         REQ_READY,
  input  logic                         REQ_WR,
  input  logic [1:0]                   REQ_CTRL,
  input  logic [MEMORY_ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [MEMORY_DATA_WIDTH-1:0] REQ_DATA,
  output logic                         BGN,
  output logic                         SI,
  output logic                         LOAD_N,
  output logic [1:0]                   CTRL,
  input  logic                         RDY,
  input  logic                         SO,
  output logic                         DONE,
  output logic [MEMORY_DATA_WIDTH-1:0] RSP_DATA,
  output logic                         TIMEOUT_ERR
);

  localparam int CW = $clog2(REG_BITS_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_WAIT  = 3'd2,
    S_CAPT  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t                       state_q;
  logic [REG_BITS_WIDTH-1:0]    shreg_q;
  logic [CW-1:0]                cnt_q;
  logic [MEMORY_DATA_WIDTH-2:0] cap_q;
  logic                         bgn_q;
  logic                         si_q;
  logic                         load_n_q;
  logic [1:0]                   ctrl_q;
  logic                         done_q;
  logic [MEMORY_DATA_WIDTH-1:0] rsp_q;
  logic [REG_BITS_WIDTH-1:0]    frame_d;

  // Read frames carry an all-zero data field.
  assign frame_d   = {REQ_ADDR, (REQ_WR ? REQ_DATA : {MEMORY_DATA_WIDTH{1'b0}})};
  assign REQ_READY = (state_q == S_IDLE);
  assign BGN       = bgn_q;
  assign SI        = si_q;
  assign LOAD_N    = load_n_q;
  assign CTRL      = ctrl_q;
  assign DONE      = done_q;
  assign RSP_DATA  = rsp_q;

`ifdef SRAM_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wcnt_q;
  logic          tmo_q;
  assign TIMEOUT_ERR = tmo_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYC != 0);
  assign TIMEOUT_ERR    = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      cap_q    <= '0;
      bgn_q    <= 1'b0;
      si_q     <= 1'b0;
      load_n_q <= 1'b1;
      ctrl_q   <= 2'b00;
      done_q   <= 1'b0;
      rsp_q    <= '0;
`ifdef SRAM_HOST_TIMEOUT_EN
      wcnt_q   <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef SRAM_HOST_TIMEOUT_EN
      tmo_q  <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (REQ_VALID) begin
            // Bit 0 goes straight to SI so it appears in the first BGN cycle.
            si_q     <= frame_d[0];
            shreg_q  <= frame_d >> 1;
            cnt_q    <= '0;
            bgn_q    <= 1'b1;
            load_n_q <= ~REQ_WR;
            ctrl_q   <= REQ_CTRL;
            state_q  <= S_SHIFT;
`ifdef SRAM_HOST_TIMEOUT_EN
            wcnt_q   <= '0;
`endif
          end
        end
        S_SHIFT: begin
          if (cnt_q == CW'(REG_BITS_WIDTH - 1)) begin
            si_q    <= 1'b0;
            state_q <= S_WAIT;
          end else begin
            si_q    <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (RDY) begin
            if (load_n_q) begin
              cnt_q   <= '0;
              state_q <= S_CAPT;
            end else begin
              bgn_q    <= 1'b0;
              load_n_q <= 1'b1;
              ctrl_q   <= 2'b00;
              done_q   <= 1'b1;
              state_q  <= S_GAP;
            end
          end
`ifdef SRAM_HOST_TIMEOUT_EN
          else if (wcnt_q == TW'(TIMEOUT_CYC - 1)) begin
            bgn_q    <= 1'b0;
            load_n_q <= 1'b1;
            ctrl_q   <= 2'b00;
            done_q   <= 1'b1;
            tmo_q    <= 1'b1;
            state_q  <= S_GAP;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
`endif
        end
        S_CAPT: begin
          cap_q <= {SO, cap_q[MEMORY_DATA_WIDTH-2:1]};
          if (cnt_q == CW'(MEMORY_DATA_WIDTH - 1)) begin
            rsp_q    <= {SO, cap_q};
            bgn_q    <= 1'b0;
            load_n_q <= 1'b1;
            ctrl_q   <= 2'b00;
            done_q   <= 1'b1;
            state_q  <= S_GAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_GAP:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_serial_host.sv
// tb_sram_serial_host: table-driven transactions plus reset, back-to-back and timeout sequences.
`default_nettype none

module tb_sram_serial_host;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic       REQ_WR = 1'b0;
  logic [1:0] REQ_CTRL = 2'b00;
  logic [8:0] REQ_ADDR = '0;
  logic [7:0] REQ_DATA = '0;
  logic       BGN, SI, LOAD_N;
  logic [1:0] CTRL;
  logic       RDY = 1'b0;
  logic       SO = 1'b0;
  logic       DONE;
  logic [7:0] RSP_DATA;
  logic       TIMEOUT_ERR;

  sram_serial_host dut (
    .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WR(REQ_WR),
    .REQ_CTRL(REQ_CTRL), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .BGN(BGN), .SI(SI),
    .LOAD_N(LOAD_N), .CTRL(CTRL), .RDY(RDY), .SO(SO), .DONE(DONE), .RSP_DATA(RSP_DATA),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;
  int tmo_cnt  = 0;
  int done_cnt = 0;

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  ctrl;
    logic [8:0]  addr;
    logic [7:0]  data;
    logic [7:0]  so;
    int          rdy_dly;
    logic        early_rdy;
    logic [16:0] exp_frame;
    logic [7:0]  exp_rsp;
    int          exp_ready;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    if (TIMEOUT_ERR === 1'b1) tmo_cnt++;
    if (DONE === 1'b1) done_cnt++;
  endtask

  task automatic run_txn(input vec_t v);
    logic [16:0] got;
    logic        hold_ok;
    int          cyc;
    int          t0;
    got = '0; hold_ok = 1'b1; cyc = 0; t0 = tmo_cnt;
    chk({v.name, ".ready_idle"}, 32'(REQ_READY), 32'd1);
    REQ_VALID = 1'b1; REQ_WR = v.wr; REQ_CTRL = v.ctrl; REQ_ADDR = v.addr; REQ_DATA = v.data;
    tick();
    // Scramble request inputs; the block must ignore them outside IDLE.
    REQ_VALID = 1'b0; REQ_WR = ~v.wr; REQ_CTRL = ~v.ctrl; REQ_ADDR = ~v.addr; REQ_DATA = ~v.data;
    for (int k = 0; k < 17; k++) begin
      got[k] = SI;
      if (BGN !== 1'b1 || LOAD_N !== ~v.wr || CTRL !== v.ctrl || DONE !== 1'b0) hold_ok = 1'b0;
      RDY = v.early_rdy && (k == 5);
      tick(); cyc++;
    end
    RDY = 1'b0;
    for (int d = 0; d < v.rdy_dly; d++) begin
      if (BGN !== 1'b1 || SI !== 1'b0 || CTRL !== v.ctrl || DONE !== 1'b0) hold_ok = 1'b0;
      tick(); cyc++;
    end
    if (BGN !== 1'b1 || SI !== 1'b0 || DONE !== 1'b0) hold_ok = 1'b0;
    RDY = 1'b1;
    tick(); cyc++;
    RDY = 1'b0;
    if (!v.wr) begin
      for (int i = 0; i < 8; i++) begin
        if (BGN !== 1'b1 || CTRL !== v.ctrl || LOAD_N !== 1'b1 || DONE !== 1'b0) hold_ok = 1'b0;
        SO = v.so[i];
        tick(); cyc++;
      end
    end
    chk({v.name, ".gap_done"}, 32'(DONE), 32'd1);
    chk({v.name, ".gap_bgn_ld_ctrl"}, {29'd0, BGN, LOAD_N, 1'b0} | 32'(CTRL), 32'b010);
    chk({v.name, ".rsp_data"}, 32'(RSP_DATA), 32'(v.exp_rsp));
    tick(); cyc++;
    chk({v.name, ".done_pulse_end"}, 32'(DONE), 32'd0);
    chk({v.name, ".ready_back"}, 32'(REQ_READY), 32'd1);
    chk({v.name, ".accept_to_ready"}, 32'(cyc + 1), 32'(v.exp_ready));
    chk({v.name, ".si_frame"}, 32'(got), 32'(v.exp_frame));
    chk({v.name, ".hold_signals"}, 32'(hold_ok), 32'd1);
    chk({v.name, ".no_timeout"}, 32'(tmo_cnt - t0), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation bound exceeded");
    $fatal(1);
  end

  initial begin
    int accepts, frames, dones0, gap_min, low_run, last_acc, bad_ivl, n;
    logic prev_bgn, rd;

    vecs[0] = '{"wr_020_34", 1'b1, 2'b00, 9'h020, 8'h34, 8'h00, 2, 1'b0, 17'h02034, 8'h00, 22};
    vecs[1] = '{"rd_001_AB", 1'b0, 2'b10, 9'h001, 8'h00, 8'hAB, 0, 1'b0, 17'h00100, 8'hAB, 28};
    vecs[2] = '{"wr_1FF_early", 1'b1, 2'b01, 9'h1FF, 8'hA5, 8'h00, 0, 1'b1, 17'h1FFA5, 8'hAB, 20};
    vecs[3] = '{"rd_155_3C", 1'b0, 2'b11, 9'h155, 8'hFF, 8'h3C, 3, 1'b1, 17'h15500, 8'h3C, 31};
    vecs[4] = '{"wr_0AA_00", 1'b1, 2'b00, 9'h0AA, 8'h00, 8'h00, 1, 1'b0, 17'h0AA00, 8'h3C, 21};

    tick(); tick();
    chk("reset.outputs", {26'd0, REQ_READY, BGN, SI, LOAD_N, CTRL}, 32'b100100);
    chk("reset.done_tmo_rsp", {22'd0, DONE, TIMEOUT_ERR, RSP_DATA}, 32'd0);
    RST = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Reset in the middle of a write frame, at bit 9.
    REQ_VALID = 1'b1; REQ_WR = 1'b1; REQ_CTRL = 2'b01; REQ_ADDR = 9'h0F0; REQ_DATA = 8'h5A;
    tick();
    REQ_VALID = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    chk("rst_mid.bgn_before", 32'(BGN), 32'd1);
    RST = 1'b1;
    #1;
    chk("rst_mid.async", {29'd0, BGN, LOAD_N, REQ_READY}, 32'b011);
    chk("rst_mid.ctrl_rsp", {22'd0, CTRL, RSP_DATA}, 32'd0);
    tick();
    RST = 1'b0;
    tick();
    run_txn(vecs[1]);

    // Back-to-back writes to 0x000..0x00D with REQ_VALID held and RDY held high.
    accepts = 0; frames = 0; dones0 = done_cnt; gap_min = 1000; low_run = 0;
    last_acc = 0; bad_ivl = 0; prev_bgn = BGN;
    RDY = 1'b1; REQ_VALID = 1'b1; REQ_WR = 1'b1; REQ_CTRL = 2'b00; REQ_ADDR = 9'h000; REQ_DATA = 8'h11;
    for (int c = 0; c < 400 && (accepts < 14 || DONE === 1'b1 || BGN === 1'b1); c++) begin
      rd = REQ_READY;
      tick();
      if (BGN === 1'b1 && prev_bgn === 1'b0) begin
        frames++;
        if (frames > 1 && low_run < gap_min) gap_min = low_run;
      end
      low_run = (BGN === 1'b0) ? low_run + 1 : 0;
      prev_bgn = BGN;
      if (rd === 1'b1) begin
        if (accepts > 0 && (c - last_acc) != 20) bad_ivl++;
        last_acc = c;
        accepts++;
        REQ_ADDR = 9'(accepts);
        if (accepts == 14) REQ_VALID = 1'b0;
      end
    end
    RDY = 1'b0;
    tick(); tick();
    chk("b2b.accepts", 32'(accepts), 32'd14);
    chk("b2b.frames", 32'(frames), 32'd14);
    chk("b2b.done_pulses", 32'(done_cnt - dones0), 32'd14);
    chk("b2b.gap_ge1", 32'(gap_min >= 1), 32'd1);
    chk("b2b.accept_interval", 32'(bad_ivl), 32'd0);
    chk("b2b.rsp_unchanged", 32'(RSP_DATA), 32'hAB);

`ifdef SRAM_HOST_TIMEOUT_EN
    REQ_VALID = 1'b1; REQ_WR = 1'b1; REQ_ADDR = 9'h033; REQ_DATA = 8'h44;
    tick();
    REQ_VALID = 1'b0;
    for (int k = 0; k < 17; k++) begin
      RDY = (k == 4);
      tick();
    end
    RDY = 1'b0;
    n = 0;
    while (DONE !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("tmo.wait_cycles", 32'(n), 32'd32);
    chk("tmo.err_pulse", {30'd0, TIMEOUT_ERR, DONE}, 32'b11);
    chk("tmo.rsp_unchanged", 32'(RSP_DATA), 32'hAB);
    tick();
    chk("tmo.ready_back", {30'd0, REQ_READY, TIMEOUT_ERR}, 32'b10);
`else
    n = 0;
    chk("notmo.err_never", 32'(tmo_cnt), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
